idram_sram_ctrl: RTL and testbench
==================================

# idram_sram_ctrl

Responder on the shared IDRAM bus: accepts the arbitrated IRAM/DRAM request stream (`idram_*`) and drives a single-port 32-bit SRAM macro that has no byte-write enables. Full-word writes and reads go straight through with one-cycle read latency. Partial writes become a read-modify-write held in a one-entry posted write buffer, with read bypass and a busy stall. Sits between the IDRAM arbiter and the SRAM macro in the Xtensa subsystem.

## Interface
Parameters:
- `AW`, 15: word-address width; the bus carries byte address bits [16:2].

Ports:
- `clk`, input, 1: sole clock; all logic on its rising edge.
- `reset_n`, input, 1: reset, synchronous, active-low.
- `idram_en`, input, 1: request valid this cycle.
- `idram_wr`, input, 1: 1 = write, 0 = read.
- `idram_addr`, input, AW: word address.
- `idram_byteen`, input, 4: byte enables; reads ignore it.
- `idram_wrdata`, input, 32: write data.
- `idram_data`, output, 32: read data, valid the cycle after an accepted read.
- `idram_busy`, output, 1: request not accepted; the requester re-presents it next cycle.
- `sram_ce`, output, 1: macro chip enable.
- `sram_we`, output, 1: macro write enable (full word).
- `sram_addr`, output, AW: macro address.
- `sram_wdata`, output, 32: macro write data.
- `sram_rdata`, input, 32: macro read data, one cycle after `ce & !we`.
- `rmw_count`, output, 16: saturating count of completed partial writes.

## Operation
- Request is accepted when `idram_en & !idram_busy`.
- **Full write** (`byteen==4'hF`): issued to the macro in the same cycle.
- **Read:** issued to the macro in the same cycle. If the buffer is valid with a matching address, return buffer data in place of `sram_rdata`; a registered hit flag selects it.
- **Partial write** (`byteen` not 0 or F) in IDLE:
  - Same cycle: macro read of `idram_addr`.
  - Latch addr, byteen and wrdata into the buffer; go to MERGE.
- **MERGE** (one cycle):
  - merged = per byte, `byteen[i] ? wrdata byte : sram_rdata byte`. Store merged in the buffer; buffer valid.
  - If `idram_en==0`: write merged to the macro this cycle, clear the buffer, increment `rmw_count`, go to IDLE.
  - Otherwise go to PEND.
- **PEND:** merged word held.
  - Drained (macro write, buffer cleared, count++, go to IDLE) on the first cycle with `idram_en==0`, or on any cycle where `idram_busy` is asserted.
- **Busy** is asserted when:
  - a partial write arrives in MERGE or PEND, or
  - any write arrives in MERGE.
- A full write in PEND to the buffer address: accepted, goes to the macro, buffer invalidated without a drain write, count not incremented.
- A full write in PEND to another address: accepted, buffer kept.
- Requests with `byteen==0`: accepted, no macro access.
- Reset (synchronous, any state): go to IDLE and clear the buffer; any pending merged word is discarded. Clear the hit flag and `rmw_count`. All outputs are 0 while reset is asserted, including `sram_ce`.

## Timing
- Read latency is 1 cycle in all states, including bypass reads.
- Partial write: 2 macro cycles (read, then write). Write completes at the earliest in the cycle after the request.
- Busy is combinational from the request and state; at most 1 busy cycle per conflicting partial write, because the buffer drains in the busy cycle.
- Macro slot priority: accepted bus request > buffer drain.
- Read of the buffer address issued in the MERGE cycle: returns merged data in the following cycle. Merged data is forwarded into the bypass register.
- `rmw_count` saturates at 16'hFFFF.

## Structure
- Package `idram_pkg`:
  - state enum IDLE/MERGE/PEND;
  - `AW` default;
  - function `byte_merge(old, new, byteen)`.
- Sub-module `idram_wbuf`: buffer registers (valid, addr, byteen, data), address-hit compare, merge datapath.
- The top level holds the FSM, macro mux, busy logic and counter.

## Test plan
- Write 0x11223344 @0x10 full, then read @0x10: `sram_we` in cycle 0, `idram_data`=0x11223344 in cycle 2, `busy` never asserted.
- Word 0x11223344 @0x10, byteen=4'b0010, wrdata 0x0000AA00, idle bus: macro read then write 0x1122AA44; `rmw_count`=1.
- Same partial write followed by back-to-back reads @0x10: first read returns 0x1122AA44 via bypass; macro write happens in the first idle cycle.
- Partial write @0x10, then partial write @0x20 next cycle: `busy`=1 for one cycle; @0x10 drained in that cycle; @0x20 accepted next; both words correct on readback.
- PEND @0x10, full write 0xDEADBEEF @0x10: buffer dropped, readback 0xDEADBEEF, `rmw_count` unchanged.
- `reset_n`=0 during MERGE: next cycle IDLE, `sram_ce`=0, `rmw_count`=0, macro word unchanged.

Source files
------------

// File: rtl/idram_pkg.sv
// idram_pkg: shared types, defaults and byte-merge helper for the IDRAM SRAM controller
package idram_pkg;

    localparam int AW_DEF = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MERGE = 2'd1,
        PEND  = 2'd2
    } state_e;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  byteen
    );
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = byteen[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/idram_wbuf.sv
// idram_wbuf: one-entry posted write buffer holding a partial write and its merged word
// Ports: load latches a new partial write, store captures the merged word, clear empties;
//        hit compares req_addr against the held address, merged/data feed macro and bypass.
module idram_wbuf
    import idram_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic          store,
    input  logic          clear,
    input  logic [AW-1:0] req_addr,
    input  logic [3:0]    req_byteen,
    input  logic [31:0]   req_wrdata,
    input  logic [31:0]   sram_rdata,
    output logic [AW-1:0] addr,
    output logic [31:0]   data,
    output logic [31:0]   merged,
    output logic          hit
);

    logic          valid_q, valid_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    byteen_q, byteen_d;
    logic [31:0]   data_q, data_d;

    always_comb begin
        merged   = byte_merge(sram_rdata, data_q, byteen_q);
        hit      = valid_q & (addr_q == req_addr);
        valid_d  = clear ? 1'b0 : (load ? 1'b1 : valid_q);
        addr_d   = load ? req_addr : addr_q;
        byteen_d = load ? req_byteen : byteen_q;
        data_d   = load ? req_wrdata : (store ? merged : data_q);
        addr     = addr_q;
        data     = data_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q  <= 1'b0;
            addr_q   <= '0;
            byteen_q <= '0;
            data_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            byteen_q <= byteen_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: rtl/idram_sram_ctrl.sv
// idram_sram_ctrl: IDRAM bus responder driving a 32-bit SRAM macro without byte enables
// Ports: idram_* request/response bus (busy stalls the requester), sram_* macro interface,
//        rmw_count saturating count of completed read-modify-write drains.
module idram_sram_ctrl
    import idram_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          idram_en,
    input  logic          idram_wr,
    input  logic [AW-1:0] idram_addr,
    input  logic [3:0]    idram_byteen,
    input  logic [31:0]   idram_wrdata,
    output logic [31:0]   idram_data,
    output logic          idram_busy,
    output logic          sram_ce,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata,
    output logic [15:0]   rmw_count
);

    logic [1:0]    state_q, state_d;
    logic          hit_q, hit_d;
    logic [31:0]   byp_q, byp_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          in_merge, in_pend, is_full, is_part, busy_raw, accept;
    logic          acc_rd, acc_full, acc_part, drain, kill;
    logic [AW-1:0] buf_addr;
    logic [31:0]   buf_data, merged, drain_data;
    logic          buf_hit;

    always_comb begin
        in_merge   = state_q == MERGE;
        in_pend    = state_q == PEND;
        is_full    = idram_byteen == 4'hF;
        is_part    = (idram_byteen != 4'h0) & !is_full;
        busy_raw   = idram_en & idram_wr & ((is_part & (in_merge | in_pend)) | in_merge);
        accept     = idram_en & !busy_raw;
        acc_rd     = accept & !idram_wr;
        acc_full   = accept & idram_wr & is_full;
        acc_part   = accept & idram_wr & is_part;
        // the macro slot is free whenever the bus is idle or the request is stalled
        drain      = (in_merge | in_pend) & (!idram_en | busy_raw);
        // a full overwrite of the buffered word makes the pending merge obsolete
        kill       = in_pend & acc_full & buf_hit;
        drain_data = in_merge ? merged : buf_data;
        state_d    = acc_part ? MERGE : (drain | kill) ? IDLE : in_merge ? PEND : state_q;
        hit_d      = acc_rd & buf_hit;
        byp_d      = in_merge ? merged : buf_data;
        cnt_d      = (drain & (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
        idram_busy = reset_n & busy_raw;
        sram_ce    = reset_n & (acc_rd | acc_full | acc_part | drain);
        sram_we    = reset_n & (acc_full | drain);
        sram_addr  = reset_n ? (drain ? buf_addr : idram_addr) : '0;
        sram_wdata = reset_n ? (drain ? drain_data : idram_wrdata) : '0;
        idram_data = reset_n ? (hit_q ? byp_q : sram_rdata) : '0;
        rmw_count  = reset_n ? cnt_q : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hit_q   <= 1'b0;
            byp_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            byp_q   <= byp_d;
            cnt_q   <= cnt_d;
        end
    end

    idram_wbuf #(.AW(AW)) u_wbuf (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (acc_part),
        .store      (in_merge & !drain),
        .clear      (drain | kill),
        .req_addr   (idram_addr),
        .req_byteen (idram_byteen),
        .req_wrdata (idram_wrdata),
        .sram_rdata (sram_rdata),
        .addr       (buf_addr),
        .data       (buf_data),
        .merged     (merged),
        .hit        (buf_hit)
    );

endmodule

// File: tb/tb_idram_sram_ctrl.sv
// tb_idram_sram_ctrl: directed scoreboard bench for idram_sram_ctrl with an SRAM macro model
module tb_idram_sram_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en, wr;
    logic [14:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] idram_data;
    logic        idram_busy;
    logic        sram_ce, sram_we;
    logic [14:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic [15:0] rmw_count;

    logic [31:0] mem [0:32767];
    logic [31:0] ref_mem [0:32767];
    logic [31:0] exp_q [$];
    logic        cap_ce, cap_we;
    logic [14:0] cap_addr;
    logic [31:0] cap_wdata;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    idram_sram_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .idram_en     (en),
        .idram_wr     (wr),
        .idram_addr   (addr),
        .idram_byteen (be),
        .idram_wrdata (wd),
        .idram_data   (idram_data),
        .idram_busy   (idram_busy),
        .sram_ce      (sram_ce),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .rmw_count    (rmw_count)
    );

    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            else sram_rdata <= mem[sram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, check busy and capture macro pins mid-cycle, then score reads.
    task automatic step(input logic e, input logic w, input logic [14:0] a, input logic [3:0] b,
                        input logic [31:0] d, input logic exp_busy);
        en = e; wr = w; addr = a; be = b; wd = d;
        #2;
        chk("busy", {31'd0, idram_busy}, {31'd0, exp_busy});
        cap_ce = sram_ce; cap_we = sram_we; cap_addr = sram_addr; cap_wdata = sram_wdata;
        if (reset_n && e && !exp_busy) begin
            if (!w) exp_q.push_back(ref_mem[a]);
            else for (int i = 0; i < 4; i++) if (b[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
        end
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) chk("rdata", idram_data, exp_q.pop_front());
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 15'h0, 4'h0, 32'h0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        en = 1'b0; wr = 1'b0; addr = '0; be = '0; wd = '0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b1, 15'h10, 4'h2, 32'hFFFFFFFF, 1'b0);
        chk("rst_ce", {31'd0, cap_ce}, 32'd0);
        chk("rst_data", idram_data, 32'd0);
        chk("rst_cnt", {16'd0, rmw_count}, 32'd0);
        reset_n = 1'b1;
        idle();

        step(1'b1, 1'b1, 15'h10, 4'hF, 32'h11223344, 1'b0);
        chk("full_we", {31'd0, cap_we}, 32'd1);
        chk("full_wdata", cap_wdata, 32'h11223344);
        step(1'b1, 1'b0, 15'h10, 4'h0, 32'h0, 1'b0);
        idle();

        step(1'b1, 1'b1, 15'h10, 4'h2, 32'h0000AA00, 1'b0);
        chk("rmw_rd_ce", {31'd0, cap_ce}, 32'd1);
        chk("rmw_rd_we", {31'd0, cap_we}, 32'd0);
        idle();
        chk("rmw_wr_we", {31'd0, cap_we}, 32'd1);
        chk("rmw_wr_addr", {17'd0, cap_addr}, 32'h10);
        chk("rmw_wr_data", cap_wdata, 32'h1122AA44);
        chk("rmw_cnt1", {16'd0, rmw_count}, 32'd1);
        step(1'b1, 1'b0, 15'h10, 4'h0, 32'h0, 1'b0);
        idle();

        step(1'b1, 1'b1, 15'h10, 4'hF, 32'h11223344, 1'b0);
        step(1'b1, 1'b1, 15'h10, 4'h2, 32'h0000AA00, 1'b0);
        step(1'b1, 1'b0, 15'h10, 4'h0, 32'h0, 1'b0);
        chk("byp1_we", {31'd0, cap_we}, 32'd0);
        step(1'b1, 1'b0, 15'h10, 4'h0, 32'h0, 1'b0);
        chk("byp2_we", {31'd0, cap_we}, 32'd0);
        idle();
        chk("byp_drain_we", {31'd0, cap_we}, 32'd1);
        chk("byp_drain_data", cap_wdata, 32'h1122AA44);
        chk("rmw_cnt2", {16'd0, rmw_count}, 32'd2);

        step(1'b1, 1'b1, 15'h10, 4'hF, 32'h11223344, 1'b0);
        step(1'b1, 1'b1, 15'h20, 4'hF, 32'h55667788, 1'b0);
        step(1'b1, 1'b1, 15'h10, 4'h2, 32'h0000AA00, 1'b0);
        step(1'b1, 1'b1, 15'h20, 4'h1, 32'h000000BB, 1'b1);
        chk("stall_drain_we", {31'd0, cap_we}, 32'd1);
        chk("stall_drain_addr", {17'd0, cap_addr}, 32'h10);
        chk("stall_drain_data", cap_wdata, 32'h1122AA44);
        step(1'b1, 1'b1, 15'h20, 4'h1, 32'h000000BB, 1'b0);
        chk("second_rd_ce", {31'd0, cap_ce}, 32'd1);
        chk("second_rd_we", {31'd0, cap_we}, 32'd0);
        idle();
        chk("second_wr_data", cap_wdata, 32'h556677BB);
        chk("rmw_cnt4", {16'd0, rmw_count}, 32'd4);
        step(1'b1, 1'b0, 15'h10, 4'h0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 15'h20, 4'h0, 32'h0, 1'b0);
        idle();

        step(1'b1, 1'b1, 15'h10, 4'h4, 32'h00CC0000, 1'b0);
        step(1'b1, 1'b0, 15'h20, 4'h0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 15'h10, 4'hF, 32'hDEADBEEF, 1'b0);
        chk("kill_we", {31'd0, cap_we}, 32'd1);
        chk("kill_data", cap_wdata, 32'hDEADBEEF);
        idle();
        chk("kill_no_drain", {31'd0, cap_ce}, 32'd0);
        chk("kill_cnt", {16'd0, rmw_count}, 32'd4);
        step(1'b1, 1'b0, 15'h10, 4'h0, 32'h0, 1'b0);
        idle();

        step(1'b1, 1'b1, 15'h20, 4'h8, 32'h99000000, 1'b0);
        step(1'b1, 1'b0, 15'h10, 4'h0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 15'h30, 4'hF, 32'hCAFEF00D, 1'b0);
        chk("other_full_addr", {17'd0, cap_addr}, 32'h30);
        idle();
        chk("keep_drain_addr", {17'd0, cap_addr}, 32'h20);
        chk("keep_drain_data", cap_wdata, 32'h996677BB);
        chk("rmw_cnt5", {16'd0, rmw_count}, 32'd5);

        step(1'b1, 1'b1, 15'h30, 4'h0, 32'hFFFFFFFF, 1'b0);
        chk("be0_ce", {31'd0, cap_ce}, 32'd0);

        step(1'b1, 1'b1, 15'h30, 4'h1, 32'h000000EE, 1'b0);
        ref_mem[15'h30] = 32'hCAFEF00D;
        reset_n = 1'b0;
        idle();
        chk("mrst_ce", {31'd0, cap_ce}, 32'd0);
        chk("mrst_cnt", {16'd0, rmw_count}, 32'd0);
        reset_n = 1'b1;
        idle();
        chk("post_rst_ce", {31'd0, cap_ce}, 32'd0);
        chk("post_rst_cnt", {16'd0, rmw_count}, 32'd0);
        step(1'b1, 1'b0, 15'h30, 4'h0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 15'h20, 4'h0, 32'h0, 1'b0);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
